axi_lite_ram_pipe: RTL and testbench
====================================

// Module: axi_lite_ram_pipe
// PURPOSE
//  Parametrised AXI4-Lite slave RAM; next generation of the NPC simulation memory.
//  Internal word array with a base-address decode window and independent AW/W capture.
//  Configurable read latency, plus a read-response FIFO that absorbs RREADY backpressure.
//  Sits behind the core's LSU/IFU AXI-Lite master; out-of-window accesses return DECERR.
// PARAMETERS
//  AWIDTH     32            address width
//  DWIDTH     64            data width, 32 or 64 only
//  DSIZE      DWIDTH/8      WSTRB width
//  DEPTH      4096          words of storage (power of 2)
//  BASE_ADDR  32'h8000_0000 first byte address of the window
//  RD_LAT     1             cycles from AR handshake to entry into the response FIFO (>=1)
//  RQ_DEPTH   4             read-response FIFO entries (power of 2, >=2)
// PORTS
//  clk      in   1       clock, all logic on posedge
//  resetn   in   1       synchronous, ACTIVE-HIGH reset (1 = reset), codebase port name
//  AWADDR   in   AWIDTH  write address
//  AWVALID  in   1       write address valid
//  AWREADY  out  1       write address ready
//  WDATA    in   DWIDTH  write data
//  WSTRB    in   DSIZE   byte enables
//  WVALID   in   1       write data valid
//  WREADY   out  1       write data ready
//  BRESP    out  2       write response
//  BVALID   out  1       write response valid
//  BREADY   in   1       write response ready
//  ARADDR   in   AWIDTH  read address
//  ARVALID  in   1       read address valid
//  ARREADY  out  1       read address ready
//  RDATA    out  DWIDTH  read data
//  RRESP    out  2       read response
//  RVALID   out  1       read data valid
//  RREADY   in   1       read data ready
// BEHAVIOUR
//  Reset: all outputs 0 (READYs forced 0 while resetn=1); holds, pipe and FIFO cleared.
//   Memory contents are kept, so reset mid-operation drops in-flight transactions only.
//  Decode: off = addr - BASE_ADDR; in range iff addr >= BASE_ADDR && off < DEPTH*DSIZE.
//   Word index = off >> log2(DSIZE); low address bits are ignored (no unaligned support).
//  Write: AW and W are captured independently into aw_hold and w_hold, in either order.
//   AWREADY = !aw_full; WREADY = !w_full (registered values).
//   Commit when aw_full && w_full && (!BVALID || BREADY): write the WSTRB bytes if in range.
//   Commit clears both holds; next cycle BVALID=1, BRESP=OKAY (2'b00), or DECERR (2'b11) with no write.
//   BVALID holds until BREADY; back-to-back BREADY=1 sustains one write every 2 cycles.
//  Read: the AR handshake samples memory in the same cycle (read-before-write).
//   A write committing in that cycle is NOT visible to that read.
//   Sampled data and resp pass a RD_LAT-stage valid pipe, then push into the FIFO.
//   Out of range: RDATA=0, RRESP=DECERR.
//   ARREADY = (fifo_count + pipe_inflight) < RQ_DEPTH; a pipe entry never stalls.
//   RVALID = !fifo_empty; RDATA/RRESP = FIFO head, stable while RVALID && !RREADY.
//   Push and pop in the same cycle are allowed when full. Peak throughput is 1 read/cycle.
//  Read and write channels are fully independent; no ordering between them.
// STRUCTURE
//  axi_lite_pkg: RESP_OKAY/SLVERR/DECERR constants, decode function, DWIDTH check.
//  Sub-module sync_fifo #(W, DEPTH): count, full/empty, registered head output.
//  Top holds the decode, aw/w holds, B register, RD_LAT pipe and credit counter.
// TESTING
//  1 Reset: resetn=1 for 3 cycles -> all outputs 0; AW/W/ARREADY=1 on the 1st cycle after release.
//  2 W before AW: W(0x1122334455667788, STRB 0xFF), 2 cycles later AW 0x80000008.
//    -> BVALID 1 cycle after the AW handshake, BRESP 0; AR 0x80000008 -> RDATA 0x1122334455667788.
//  3 Strobe: write STRB 0x0F of 0xAAAAAAAA_BBBBBBBB over 0 -> read 0x00000000_BBBBBBBB.
//  4 Backpressure: RD_LAT=2, RQ_DEPTH=4, RREADY=0, 6 back-to-back ARs -> exactly 4 accepted.
//    ARREADY=0 from then; with RREADY=1, data drains in order and ARREADY recovers.
//  5 Decode: AR 0x7FFFFFF8 and AW/W 0x80000000+DEPTH*DSIZE -> RRESP/BRESP 2'b11, RDATA 0, memory unchanged.
//  6 Same-cycle: AR and write commit to the same address, old 0x1, new 0x2 -> RDATA 0x1; next read -> 0x2.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite RAM slice.
//   resp_e          : AXI response codes (OKAY / EXOKAY / SLVERR / DECERR)
//   addr_in_window  : address window decode helper
//   dwidth_ok       : legal data widths for the RAM (32 or 64)
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // The subtraction only runs when addr >= base, so it never wraps.
    function automatic logic addr_in_window(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input logic [63:0] win_bytes);
        return (addr >= base) && ((addr - base) < win_bytes);
    endfunction

    function automatic logic dwidth_ok(input int unsigned w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/axi_lite_ram_pipe_fifo.sv
// sync_fifo: synchronous FIFO that holds read responses until the master takes them.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i / data_i     : write one entry (ignored when full without a pop)
//   pop_i               : remove the head entry (ignored when empty)
//   data_o              : head entry, taken straight from the storage registers
//   empty_o / full_o    : status flags
//   count_o             : current number of entries
// A push and a pop in the same cycle are accepted even when full.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [W-1:0]                   data_i,
    input  logic                           pop_i,
    output logic [W-1:0]                   data_o,
    output logic                           empty_o,
    output logic                           full_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_lite_ram_pipe.sv
// axi_lite_ram_pipe: AXI4-Lite slave RAM with a decode window, independent
// AW/W capture, RD_LAT-stage read pipe and a read-response FIFO.
//   clk, resetn (synchronous, active-high: 1 = reset)
//   AW*: write address channel   W*: write data channel   B*: write response
//   AR*: read address channel    R*: read data channel
// Out-of-window accesses answer DECERR; reads return 0 and writes are dropped.
module axi_lite_ram_pipe
    import axi_lite_pkg::*;
#(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 64,
    parameter int unsigned       DSIZE     = DWIDTH / 8,
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h8000_0000),
    parameter int unsigned       RD_LAT    = 1,
    parameter int unsigned       RQ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [AWIDTH-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DWIDTH-1:0] WDATA,
    input  logic [DSIZE-1:0]  WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [AWIDTH-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DWIDTH-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY
);
    localparam int unsigned OFF_W     = $clog2(DSIZE);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned CW        = $clog2(RQ_DEPTH + 1);
    localparam logic [63:0] WIN_BYTES = 64'(DEPTH) * 64'(DSIZE);

    if (!dwidth_ok(DWIDTH)) begin : g_bad_dwidth
        $error("axi_lite_ram_pipe: DWIDTH must be 32 or 64");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("axi_lite_ram_pipe: RD_LAT must be at least 1");
    end

    logic [DWIDTH-1:0] mem [DEPTH];

    // ---------------- write path ----------------
    logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic              bvalid_q, bvalid_d;
    resp_e             bresp_q, bresp_d;
    logic [AWIDTH-1:0] aw_addr_q;
    logic [DWIDTH-1:0] w_data_q;
    logic [DSIZE-1:0]  w_strb_q;
    logic              aw_hs, w_hs, commit, aw_in_win;
    logic [IDX_W-1:0]  aw_idx;

    assign AWREADY = !resetn && !aw_full_q;
    assign WREADY  = !resetn && !w_full_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    // Commit only when the B register is free or being drained this cycle.
    assign commit    = aw_full_q && w_full_q && (!bvalid_q || BREADY);
    assign aw_in_win = addr_in_window(64'(aw_addr_q), 64'(BASE_ADDR), WIN_BYTES);
    assign aw_idx    = IDX_W'((aw_addr_q - BASE_ADDR) >> OFF_W);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_win ? RESP_OKAY : RESP_DECERR;
        end else if (BREADY) begin
            bvalid_d  = 1'b0;
        end
        // A hold can only be captured while empty, so never collides with commit.
        if (aw_hs) aw_full_d = 1'b1;
        if (w_hs)  w_full_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr_q <= AWADDR;
        if (w_hs) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
        end
    end

    // ---------------- read path ----------------
    logic [RD_LAT-1:0] pv_q;
    logic [DWIDTH-1:0] pd_q [RD_LAT];
    resp_e             pr_q [RD_LAT];
    logic              ar_hs, ar_in_win, r_pop;
    logic [IDX_W-1:0]  ar_idx;
    logic [DWIDTH+1:0] fifo_head;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       outstanding;

    assign ar_hs     = ARVALID && ARREADY;
    assign r_pop     = RVALID && RREADY;
    assign ar_in_win = addr_in_window(64'(ARADDR), 64'(BASE_ADDR), WIN_BYTES);
    assign ar_idx    = IDX_W'((ARADDR - BASE_ADDR) >> OFF_W);

    // Every accepted read already owns a FIFO slot, so the pipe never stalls.
    assign outstanding = 32'(fifo_count) + 32'($countones(pv_q));
    assign ARREADY     = !resetn && (outstanding < RQ_DEPTH);

    always_ff @(posedge clk) begin
        if (resetn) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= ar_hs;
            for (int i = 1; i < int'(RD_LAT); i++) pv_q[i] <= pv_q[i-1];
        end
    end

    // Memory write and read sample share one edge: the read sees the
    // pre-commit contents, giving read-before-write ordering.
    always_ff @(posedge clk) begin
        if (commit && aw_in_win) begin
            for (int b = 0; b < int'(DSIZE); b++) begin
                if (w_strb_q[b]) mem[aw_idx][8*b +: 8] <= w_data_q[8*b +: 8];
            end
        end
        if (ar_hs) begin
            pd_q[0] <= ar_in_win ? mem[ar_idx] : '0;
            pr_q[0] <= ar_in_win ? RESP_OKAY : RESP_DECERR;
        end
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pd_q[i] <= pd_q[i-1];
            pr_q[i] <= pr_q[i-1];
        end
    end

    sync_fifo #(
        .W     (DWIDTH + 2),
        .DEPTH (RQ_DEPTH)
    ) u_rq (
        .clk_i   (clk),
        .rst_i   (resetn),
        .push_i  (pv_q[RD_LAT-1]),
        .data_i  ({pr_q[RD_LAT-1], pd_q[RD_LAT-1]}),
        .pop_i   (r_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign RVALID = !fifo_empty;
    // Gate the head so idle and reset cycles present zeros on the R channel.
    assign RDATA  = RVALID ? fifo_head[DWIDTH-1:0] : '0;
    assign RRESP  = RVALID ? fifo_head[DWIDTH+1:DWIDTH] : 2'b00;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_axi_lite_ram_pipe.sv
// Directed bench for axi_lite_ram_pipe (DWIDTH 64, RD_LAT 2, RQ_DEPTH 4).
module tb_axi_lite_ram_pipe;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_ram_pipe #(
        .RD_LAT   (2),
        .RQ_DEPTH (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, output logic [1:0] resp);
        logic seen;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (AWREADY && WREADY) begin seen = 1'b1; break; end
            tick();
        end
        check("wr_ready_seen", 64'(seen), 64'd1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1; seen = 1'b0; resp = 2'bxx;
        for (int n = 0; n < 20; n++) begin
            if (BVALID) begin seen = 1'b1; resp = BRESP; break; end
            tick();
        end
        check("wr_bvalid_seen", 64'(seen), 64'd1);
        tick();
        BREADY = 1'b0;
    endtask

    task automatic get_r(output logic [63:0] data, output logic [1:0] resp);
        logic seen;
        RREADY = 1'b1; seen = 1'b0; data = 'x; resp = 2'bxx;
        for (int n = 0; n < 20; n++) begin
            if (RVALID) begin seen = 1'b1; data = RDATA; resp = RRESP; break; end
            tick();
        end
        check("rd_rvalid_seen", 64'(seen), 64'd1);
        tick();
        RREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [63:0] data,
                            output logic [1:0] resp);
        logic seen;
        ARADDR = addr; ARVALID = 1'b1; seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ARREADY) begin seen = 1'b1; break; end
            tick();
        end
        check("rd_arready_seen", 64'(seen), 64'd1);
        tick();
        ARVALID = 1'b0;
        get_r(data, resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [1:0]  rs;
        int          acc;

        resetn = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // 1: reset
        repeat (3) tick();
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_wready",  64'(WREADY),  64'd0);
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_bvalid",  64'(BVALID),  64'd0);
        check("rst_rvalid",  64'(RVALID),  64'd0);
        check("rst_bresp",   64'(BRESP),   64'd0);
        check("rst_rdata",   RDATA,        64'd0);
        resetn = 1'b0;
        #1;
        check("rel_awready", 64'(AWREADY), 64'd1);
        check("rel_wready",  64'(WREADY),  64'd1);
        check("rel_arready", 64'(ARREADY), 64'd1);
        tick();

        // 2: W two cycles before AW
        WDATA = 64'h1122334455667788; WSTRB = 8'hFF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("wfirst_wready_held", 64'(WREADY), 64'd0);
        tick();
        AWADDR = 32'h8000_0008; AWVALID = 1'b1;
        check("wfirst_awready", 64'(AWREADY), 64'd1);
        tick();
        AWVALID = 1'b0;
        check("wfirst_bvalid_early", 64'(BVALID), 64'd0);
        tick();
        check("wfirst_bvalid", 64'(BVALID), 64'd1);
        check("wfirst_bresp",  64'(BRESP),  64'd0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("wfirst_bvalid_clr", 64'(BVALID), 64'd0);
        axi_read(32'h8000_0008, rd, rs);
        check("wfirst_rdata", rd, 64'h1122334455667788);
        check("wfirst_rresp", 64'(rs), 64'd0);

        // 3: partial strobe
        axi_write(32'h8000_0010, 64'h0, 8'hFF, rs);
        axi_write(32'h8000_0010, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, rs);
        check("strb_bresp", 64'(rs), 64'd0);
        axi_read(32'h8000_0010, rd, rs);
        check("strb_rdata", rd, 64'h00000000_BBBBBBBB);

        // 4: read backpressure
        for (int i = 0; i < 6; i++)
            axi_write(32'h8000_0100 + 32'(8 * i), 64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, rs);
        acc = 0;
        ARVALID = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ARADDR = 32'h8000_0100 + 32'(8 * acc);
            if (ARREADY) acc++;
            tick();
        end
        ARVALID = 1'b0;
        check("bp_accepted", 64'(acc), 64'd4);
        check("bp_arready_low", 64'(ARREADY), 64'd0);
        repeat (3) tick();
        check("bp_rvalid_held", 64'(RVALID), 64'd1);
        check("bp_rdata_stable", RDATA, 64'hC0DE_0000_0000_0000);
        check("bp_arready_still_low", 64'(ARREADY), 64'd0);
        for (int k = 0; k < 4; k++) begin
            get_r(rd, rs);
            check($sformatf("bp_drain%0d", k), rd, 64'hC0DE_0000_0000_0000 + 64'(k));
        end
        check("bp_rvalid_empty", 64'(RVALID), 64'd0);
        check("bp_arready_back", 64'(ARREADY), 64'd1);

        // 5: decode window
        axi_write(32'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, rs);
        axi_read(32'h7FFF_FFF8, rd, rs);
        check("dec_low_rresp", 64'(rs), 64'd3);
        check("dec_low_rdata", rd, 64'd0);
        axi_write(32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rs);
        check("dec_high_bresp", 64'(rs), 64'd3);
        axi_read(32'h8000_0000, rd, rs);
        check("dec_mem_unchanged", rd, 64'h0123456789ABCDEF);
        axi_write(32'h8000_7FF8, 64'h5A5A_0000_0000_A5A5, 8'hFF, rs);
        check("dec_last_bresp", 64'(rs), 64'd0);
        axi_read(32'h8000_7FF8, rd, rs);
        check("dec_last_rdata", rd, 64'h5A5A_0000_0000_A5A5);

        // 6: read and write commit on the same edge
        axi_write(32'h8000_0020, 64'h1, 8'hFF, rs);
        AWADDR = 32'h8000_0020; WDATA = 64'h2; WSTRB = 8'hFF;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h8000_0020; ARVALID = 1'b1;
        check("same_arready", 64'(ARREADY), 64'd1);
        tick();
        ARVALID = 1'b0;
        check("same_bvalid", 64'(BVALID), 64'd1);
        check("same_bresp", 64'(BRESP), 64'd0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        get_r(rd, rs);
        check("same_old_data", rd, 64'h1);
        axi_read(32'h8000_0020, rd, rs);
        check("same_new_data", rd, 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
